// File: rtl/alu_issue_sequencer_if.sv
// alu_issue_sequencer_if: instruction, load, debug, ALU and completion signals of the sequencer
interface alu_issue_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int OP_W = 5,
  parameter int IDX_W = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   instr_op;
  logic [IDX_W-1:0]  instr_rd;
  logic [IDX_W-1:0]  instr_rs;
  logic [IDX_W-1:0]  instr_rt;
  logic              ld_valid;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;
  logic [IDX_W-1:0]  dbg_idx;
  logic [DATA_W-1:0] dbg_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              alu_error;
  logic              alu_zero;
  logic              alu_carry;
  logic              alu_overflow;
  logic              done_valid;
  logic [DATA_W-1:0] done_result;
  logic [3:0]        flags_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt, ld_valid, ld_idx, ld_data, dbg_idx,
           alu_out, alu_error, alu_zero, alu_carry, alu_overflow,
    output instr_ready, dbg_data, alu_a, alu_b, alu_sel, done_valid, done_result, flags_q, hi_q, lo_q
  );
  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_rt, ld_valid, ld_idx, ld_data, dbg_idx,
           alu_out, alu_error, alu_zero, alu_carry, alu_overflow,
    input  instr_ready, dbg_data, alu_a, alu_b, alu_sel, done_valid, done_result, flags_q, hi_q, lo_q
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: issues register-file operands to an external ALU and writes results back;
// MULT runs on a local shift-add unit into HI/LO, MFHI/MFLO are served without the ALU.
module alu_issue_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W = 5,
  parameter int NREG = 4,
  parameter int IDX_W = 2,
  parameter logic [OP_W-1:0] OP_MULT = OP_W'(10),
  parameter logic [OP_W-1:0] OP_MFHI = OP_W'(12),
  parameter logic [OP_W-1:0] OP_MFLO = OP_W'(13)
) (
  input logic clk,
  input logic rst_n,
  alu_issue_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2;
  localparam int CNT_W = $clog2(DATA_W);
  logic [1:0] state_q, state_d;
  logic [NREG-1:0][DATA_W-1:0] rf_q, rf_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] done_result_q, done_result_d;
  logic [OP_W-1:0] alu_sel_q, alu_sel_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d, pp;
  logic [3:0] flags_q, flags_d;
  logic done_valid_q, done_valid_d;
  logic bypass, exec_err;
  logic [DATA_W-1:0] exec_res;
  assign bypass = alu_sel_q == OP_MFHI || alu_sel_q == OP_MFLO;
  assign exec_res = alu_sel_q == OP_MFHI ? hi_q : alu_sel_q == OP_MFLO ? lo_q : bus.alu_out;
  assign exec_err = !bypass && bus.alu_error;
  // partial product of the current multiplier bit
  assign pp = alu_b_q[cnt_q] ? {{DATA_W{1'b0}}, alu_a_q} << cnt_q : '0;
  always_comb begin
    state_d = state_q;
    rf_d = rf_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_sel_d = alu_sel_q;
    rd_d = rd_q;
    hi_d = hi_q;
    lo_d = lo_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    flags_d = flags_q;
    done_result_d = done_result_q;
    done_valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.ld_valid) begin
        rf_d[bus.ld_idx] = bus.ld_data;
      end else if (bus.instr_valid) begin
        rd_d = bus.instr_rd;
        alu_a_d = rf_q[bus.instr_rs];
        alu_b_d = rf_q[bus.instr_rt];
        alu_sel_d = bus.instr_op;
        cnt_d = '0;
        acc_d = '0;
        state_d = bus.instr_op == OP_MULT ? MUL : EXEC;
      end
    end else if (state_q == EXEC) begin
      if (!exec_err) rf_d[rd_q] = exec_res;
      flags_d = bypass ? {3'b000, exec_res == '0}
                       : {bus.alu_error, bus.alu_overflow, bus.alu_carry, bus.alu_zero};
      done_result_d = exec_res;
      done_valid_d = 1'b1;
      state_d = IDLE;
    end else if (state_q == MUL) begin
      acc_d = acc_q + pp;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        {hi_d, lo_d} = acc_d;
        done_result_d = acc_d[DATA_W-1:0];
        flags_d = {2'b00, acc_d[2*DATA_W-1:DATA_W] != '0, acc_d == '0};
        done_valid_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rf_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_sel_q <= '0;
      rd_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      flags_q <= '0;
      done_result_q <= '0;
      done_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rf_q <= rf_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      rd_q <= rd_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      flags_q <= flags_d;
      done_result_q <= done_result_d;
      done_valid_q <= done_valid_d;
    end
  end
  assign bus.instr_ready = state_q == IDLE && !bus.ld_valid;
  assign bus.dbg_data = rf_q[bus.dbg_idx];
  assign bus.alu_a = alu_a_q;
  assign bus.alu_b = alu_b_q;
  assign bus.alu_sel = alu_sel_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_result = done_result_q;
  assign bus.flags_q = flags_q;
  assign bus.hi_q = hi_q;
  assign bus.lo_q = lo_q;
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb_alu_issue_sequencer: randomized and directed checks of the sequencer against a reference model
module tb_alu_issue_sequencer;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, OR_ = 5'd3, XOR_ = 5'd4;
  localparam logic [4:0] MULT = 5'd10, DIV = 5'd11, MFHI = 5'd12, MFLO = 5'd13;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] ref_rf [4];
  logic [7:0] ref_hi = '0;
  logic [7:0] ref_lo = '0;
  logic [4:0] ops [10] = '{ADD, SUB, AND_, OR_, XOR_, MULT, DIV, MFHI, MFLO, 5'd31};
  alu_issue_sequencer_if bus ();
  alu_issue_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // external ALU: {error, overflow, carry, zero, result}
  function automatic logic [11:0] alu_ref(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic e, v, c;
    e = 1'b0; v = 1'b0; c = 1'b0; r = '0;
    if (op == ADD) begin
      s = {1'b0, a} + {1'b0, b};
      r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]);
    end else if (op == SUB) begin
      r = a - b; c = a < b; v = (a[7] != b[7]) && (r[7] != a[7]);
    end else if (op == AND_) r = a & b;
    else if (op == OR_) r = a | b;
    else if (op == XOR_) r = a ^ b;
    else if (op == DIV && b != 0) r = a / b;
    else e = 1'b1;
    return {e, v, c, !e && r == 0, r};
  endfunction
  assign {bus.alu_error, bus.alu_overflow, bus.alu_carry, bus.alu_zero, bus.alu_out} =
    alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [1:0] idx, input logic [7:0] data);
    bus.ld_valid = 1'b1; bus.ld_idx = idx; bus.ld_data = data;
    tick();
    bus.ld_valid = 1'b0;
    ref_rf[idx] = data;
  endtask
  task automatic check_rf();
    for (int i = 0; i < 4; i++) begin
      bus.dbg_idx = 2'(i);
      #1;
      chk($sformatf("rf%0d", i), bus.dbg_data, ref_rf[i]);
    end
  endtask
  task automatic issue(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input bit keep);
    logic [7:0] a, b, res;
    logic [3:0] fl;
    logic [15:0] p;
    logic [11:0] r;
    int n, lat;
    a = ref_rf[rs]; b = ref_rf[rt];
    if (op == MULT) begin
      p = {8'h00, a} * {8'h00, b};
      ref_hi = p[15:8]; ref_lo = p[7:0];
      res = p[7:0]; fl = {2'b00, p[15:8] != 0, p == 0}; lat = 8;
    end else if (op == MFHI || op == MFLO) begin
      res = op == MFHI ? ref_hi : ref_lo;
      fl = {3'b000, res == 0}; ref_rf[rd] = res; lat = 1;
    end else begin
      r = alu_ref(op, a, b);
      res = r[7:0]; fl = r[11:8]; lat = 1;
      if (!r[11]) ref_rf[rd] = res;
    end
    bus.instr_valid = 1'b1; bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs = rs; bus.instr_rt = rt;
    #1;
    n = 0;
    while (!bus.instr_ready && n < 20) begin tick(); n++; end
    chk("accept", {31'b0, bus.instr_ready}, 1);
    tick();
    if (!keep) bus.instr_valid = 1'b0;
    n = 0;
    while (!bus.done_valid && n < 20) begin tick(); n++; end
    chk("latency", n, lat);
    chk("result", bus.done_result, res);
    chk("flags", bus.flags_q, fl);
    chk("hi", bus.hi_q, ref_hi);
    chk("lo", bus.lo_q, ref_lo);
    chk("ready", {31'b0, bus.instr_ready}, 1);
    bus.dbg_idx = rd;
    #1;
    chk("rf_rd", bus.dbg_data, ref_rf[rd]);
  endtask
  initial begin
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rd = '0; bus.instr_rs = '0; bus.instr_rt = '0;
    bus.ld_valid = 1'b0; bus.ld_idx = '0; bus.ld_data = '0; bus.dbg_idx = '0;
    for (int i = 0; i < 4; i++) ref_rf[i] = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'b0, bus.instr_ready}, 1);
    chk("rst_done", {31'b0, bus.done_valid}, 0);
    chk("rst_flags", bus.flags_q, 0);
    chk("rst_hi", bus.hi_q, 0);
    chk("rst_lo", bus.lo_q, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_result", bus.done_result, 0);
    check_rf();
    load(1, 8'h05); load(2, 8'h03);
    issue(ADD, 0, 1, 2, 0);
    load(1, 8'hFF); load(2, 8'h01);
    issue(ADD, 3, 1, 2, 0);
    load(1, 8'hFF); load(2, 8'hFF);
    issue(MULT, 0, 1, 2, 0);
    chk("mult_hi", bus.hi_q, 8'hFE);
    chk("mult_lo", bus.lo_q, 8'h01);
    issue(MFHI, 3, 0, 0, 0);
    chk("mfhi_rf3", bus.dbg_data, 8'hFE);
    load(2, 8'h00);
    issue(DIV, 1, 1, 2, 0);
    chk("div0_err", {31'b0, bus.flags_q[3]}, 1);
    tick();
    chk("pulse", {31'b0, bus.done_valid}, 0);
    // load and instruction offered together: load wins, instructions then run back to back
    bus.instr_valid = 1'b1; bus.instr_op = ADD; bus.instr_rd = 0; bus.instr_rs = 1; bus.instr_rt = 2;
    bus.ld_valid = 1'b1; bus.ld_idx = 1; bus.ld_data = 8'h10;
    #1;
    chk("ld_prio_ready", {31'b0, bus.instr_ready}, 0);
    tick();
    bus.ld_valid = 1'b0;
    ref_rf[1] = 8'h10;
    issue(ADD, 0, 1, 2, 1);
    issue(ADD, 1, 0, 1, 1);
    issue(ADD, 2, 1, 0, 0);
    check_rf();
    // reset in the middle of a multiply
    load(1, 8'h37); load(2, 8'h5A);
    bus.instr_valid = 1'b1; bus.instr_op = MULT; bus.instr_rd = 0; bus.instr_rs = 1; bus.instr_rt = 2;
    tick();
    bus.instr_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_hi", bus.hi_q, 0);
    chk("abort_lo", bus.lo_q, 0);
    chk("abort_ready", {31'b0, bus.instr_ready}, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) ref_rf[i] = '0;
    ref_hi = '0; ref_lo = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_done", {31'b0, bus.done_valid}, 0);
    end
    chk("abort_ready2", {31'b0, bus.instr_ready}, 1);
    check_rf();
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) < 3) load(2'($urandom_range(0, 3)), 8'($urandom));
      else begin
        issue(ops[$urandom_range(0, 9)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 0);
        tick();
        chk("pulse", {31'b0, bus.done_valid}, 0);
      end
    end
    check_rf();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Drives the combinational 8-bit ALU: accepts instructions over a valid/ready handshake and reads operands from a local 4x8 register file.
- Issues a/b/sel to the ALU, captures the result and flags, and writes the result back.
- Executes MULT itself with an iterative shift-add unit into HI/LO registers, and serves MFHI/MFLO locally.
- Sits between instruction source/test bench and the ALU.

Parameters:
- DATA_W, 8, operand/result width; must match ALU OPERAND_WIDTH.
- OP_W, 5, opcode width; must match ALU SEL_WIDTH.
- NREG, 4, register-file depth.
- IDX_W, 2, register index width, equal to log2(NREG).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept.
- instr_op  in  OP_W  opcode; encodings from the shared ALU constants header.
- instr_rd / instr_rs / instr_rt  in  IDX_W each  destination, source A, source B.
- ld_valid  in  1  register-file load strobe.
- ld_idx  in  IDX_W  load index.
- ld_data  in  DATA_W  load data.
- dbg_idx  in  IDX_W  debug read index.
- dbg_data  out  DATA_W  rf[dbg_idx], combinational.
- alu_a, alu_b  out  DATA_W  registered ALU operands.
- alu_sel  out  OP_W  registered ALU opcode.
- alu_out  in  DATA_W  ALU result.
- alu_error, alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags.
- done_valid  out  1  one-cycle completion pulse.
- done_result  out  DATA_W  result of the completed instruction.
- flags_q  out  4  latched {error, overflow, carry, zero}.
- hi_q, lo_q  out  DATA_W  HI/LO registers.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rf, HI, LO, alu_a, alu_b, alu_sel, done_result, flags_q all 0; done_valid=0.
- instr_ready = (state==IDLE) && !ld_valid.
- States:
  - IDLE: if ld_valid, write rf[ld_idx]=ld_data, stay IDLE. Load has priority over instructions; loads are ignored outside IDLE.
  - IDLE, else if instr_valid: accept. Latch op and rd; latch alu_a=rf[rs], alu_b=rf[rt], alu_sel=op. MULT goes to MUL; all other ops go to EXEC.
  - EXEC (1 cycle): ALU evaluates.
    - At the closing edge: done_result=alu_out; done_valid=1 next cycle; return to IDLE.
    - rf[rd]=alu_out unless alu_error=1, in which case rd is unchanged.
    - flags_q={alu_error, alu_overflow, alu_carry, alu_zero}.
  - MFHI/MFLO take the EXEC path but bypass the ALU:
    - result=HI (resp. LO), written to rd.
    - flags_q={0,0,0,result==0}.
  - MUL: 16-bit unsigned shift-add over exactly DATA_W cycles, counter 0..DATA_W-1.
    - At the edge ending iteration DATA_W-1: {HI,LO}=product; done_result=LO; done_valid=1 next cycle; return to IDLE.
    - rd is not written.
    - flags_q={0,0,HI!=0,product==0}.
- Operands are sampled at acceptance, so rd==rs/rt hazards are impossible and back-to-back instructions see the prior writeback.
- Latency, with acceptance at edge E0:
  - Non-MULT: writeback/flags at E1, done_valid high in the cycle after E1.
  - MULT: HI/LO at E8, done_valid in the cycle after E8.
- Throughput: one non-MULT instruction per 2 cycles, since instr_ready is low in EXEC and during the done cycle only if the state is not IDLE.
- done_valid is high for exactly 1 cycle, with no backpressure.
- Unknown opcode: forwarded to the ALU; alu_error=1 yields flags_q.error=1 with rd unchanged.
- Divide by zero: same handling as an unknown opcode.
- Reset mid-MUL/EXEC: instruction is aborted, no done pulse, HI/LO=0.

Test Plan:
- Reset; load r1=0x05, r2=0x03; ADD rd=0 rs=1 rt=2 -> done_valid 2 cycles after acceptance, done_result=0x08, rf[0]=0x08, flags_q=4'b0000.
- Load r1=0xFF, r2=0x01; ADD rd=3 -> rf[3]=0x00, flags_q zero=1, carry=1.
- Load r1=r2=0xFF; MULT -> done_valid 9 cycles after acceptance, hi_q=0xFE, lo_q=0x01, flags_q carry=1. Then MFHI rd=3 -> rf[3]=0xFE.
- r2=0x00; DIVIDE rd=1 rs=1 rt=2 -> flags_q error=1, rf[1] unchanged; ready returns next cycle.
- Hold instr_valid=1 with 3 ADDs and assert ld_valid in one IDLE cycle -> load is applied first (instr_ready=0 that cycle), then instructions complete in order, one done pulse per instruction, none dropped.
- Assert rst_n=0 at MUL iteration 4 -> no done_valid, hi_q=lo_q=0, state IDLE, instr_ready=1 after release.
